// File: rtl/md_pkg.sv
// Shared constants for the EX-stage multiply/divide unit:
// default width, op codes and FSM state encoding.
package md_pkg;

  localparam int WIDTH = 32;

  localparam logic [2:0] MD_NOP   = 3'b000;
  localparam logic [2:0] MD_MULT  = 3'b001;
  localparam logic [2:0] MD_MULTU = 3'b010;
  localparam logic [2:0] MD_DIV   = 3'b011;
  localparam logic [2:0] MD_DIVU  = 3'b100;
  localparam logic [2:0] MD_MTHI  = 3'b101;
  localparam logic [2:0] MD_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 datapath: 2W accumulator, shift-add multiply step,
// restoring divide step and the iteration down-counter.
module md_iter_core
  import md_pkg::*;
#(
  parameter int W = md_pkg::WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           step,
  input  logic           clr,
  input  logic           mode,
  input  logic [W-1:0]   ma,
  input  logic [W-1:0]   mb,
  output logic [2*W-1:0] acc,
  output logic           last
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]   opd;
  logic [CW-1:0]  cnt;
  logic           mode_q;
  logic [W:0]     msum;
  logic [W:0]     rsh;
  logic [W:0]     dif;
  logic [2*W-1:0] mul_nxt;
  logic [2*W-1:0] div_nxt;

  // Multiply: add multiplicand to upper half, shift right with carry.
  always_comb begin
    msum    = {1'b0, acc[2*W-1:W]}
            + {1'b0, (acc[0] ? opd : {W{1'b0}})};
    mul_nxt = {msum, acc[W-1:1]};
  end

  // Divide: shift remainder in, trial subtract, restore on borrow.
  always_comb begin
    rsh = {acc[2*W-1:W], acc[W-1]};
    dif = rsh - {1'b0, opd};
    if (dif[W])
      div_nxt = {rsh[W-1:0], acc[W-2:0], 1'b0};
    else
      div_nxt = {dif[W-1:0], acc[W-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      opd    <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
    end else if (load) begin
      acc    <= {{W{1'b0}}, ma};
      opd    <= mb;
      cnt    <= CW'(W);
      mode_q <= mode;
    end else if (step) begin
      acc    <= mode_q ? div_nxt : mul_nxt;
      cnt    <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CW'(1));

endmodule

// File: rtl/muldiv_hilo_unit.sv
// EX-stage iterative mult/div unit owning HI/LO; busy stalls
// the front end while a 33-cycle operation is in flight.
module muldiv_hilo_unit
  import md_pkg::*;
#(
  parameter int WIDTH = md_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W = WIDTH;

  md_state_t state;
  md_state_t nstate;

  logic is_mul;
  logic is_div;
  logic is_sgn;
  logic is_md;
  logic go;
  logic sa;
  logic sb;
  logic [W-1:0] ma;
  logic [W-1:0] mb;

  logic core_load;
  logic core_step;
  logic core_clr;
  logic fix_wr;
  logic mv_hi;
  logic mv_lo;
  logic last;

  logic [2*W-1:0] acc;
  logic [2*W-1:0] pneg;
  logic [W-1:0]   res_hi;
  logic [W-1:0]   res_lo;

  logic         neg_q;
  logic         neg_r;
  logic         divz;
  logic         mode_q;
  logic [W-1:0] a_q;
  logic         done_q;

  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    is_sgn = 1'b0;
    unique case (op)
      MD_MULT: begin
        is_mul = 1'b1;
        is_sgn = 1'b1;
      end
      MD_MULTU: is_mul = 1'b1;
      MD_DIV: begin
        is_div = 1'b1;
        is_sgn = 1'b1;
      end
      MD_DIVU: is_div = 1'b1;
      default: ;
    endcase
  end

  assign is_md = is_mul | is_div;
  assign go    = start & ~cancel;

  // Magnitude of the most negative value stays exact as unsigned W bits.
  assign sa = is_sgn & a[W-1];
  assign sb = is_sgn & b[W-1];
  assign ma = sa ? (~a + 1'b1) : a;
  assign mb = sb ? (~b + 1'b1) : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (go && is_md) nstate = ITER;
      ITER: begin
        if (cancel)    nstate = IDLE;
        else if (last) nstate = FIX;
      end
      FIX:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    core_load = 1'b0;
    core_step = 1'b0;
    core_clr  = 1'b0;
    fix_wr    = 1'b0;
    mv_hi     = 1'b0;
    mv_lo     = 1'b0;
    unique case (state)
      IDLE: begin
        core_load = go & is_md;
        mv_hi     = go & (op == MD_MTHI);
        mv_lo     = go & (op == MD_MTLO);
      end
      ITER: begin
        core_step = ~cancel;
        core_clr  = cancel;
      end
      FIX: begin
        fix_wr    = ~cancel;
        core_clr  = cancel;
      end
      default: ;
    endcase
  end

  md_iter_core #(
    .W (W)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (core_load),
    .step  (core_step),
    .clr   (core_clr),
    .mode  (is_div),
    .ma    (ma),
    .mb    (mb),
    .acc   (acc),
    .last  (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      divz   <= 1'b0;
      mode_q <= 1'b0;
      a_q    <= '0;
    end else if (core_load) begin
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      divz   <= is_div & (b == '0);
      mode_q <= is_div;
      a_q    <= a;
    end
  end

  // Quotient follows sign(a)^sign(b); remainder follows sign(a).
  always_comb begin
    pneg   = ~acc + 1'b1;
    res_hi = acc[2*W-1:W];
    res_lo = acc[W-1:0];
    if (!mode_q) begin
      if (neg_q) {res_hi, res_lo} = pneg;
    end else if (divz) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      if (neg_q) res_lo = ~acc[W-1:0] + 1'b1;
      if (neg_r) res_hi = ~acc[2*W-1:W] + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi     <= '0;
      lo     <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fix_wr | mv_hi | mv_lo;
      if (fix_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (mv_hi) hi <= a;
        if (mv_lo) lo <= a;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;

endmodule
